// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// legal frame-length bounds and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'd8;

    // Even parity (XOR) over the low `length` bits of data; callers invert for odd.
    function automatic logic parity_calc(input logic [7:0] data, input logic [3:0] length);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < length) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; rst (active-low) empties the FIFO at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised LSB
// first with a programmable bit period, frame length, parity and stop bits.
//
// Input handshake: a word transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is simply "FIFO not full"; it does not look
// at the pop in the same cycle, and in_data is ignored on any other edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        tx_clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [3:0]                  length,
    input  logic                        parity_en,
    input  logic                        parity_type,
    input  logic                        stop2,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        tx_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    uart_state_t      state;
    uart_state_t      state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic             tx_next;
    logic             done_next;
    logic             err_next;
    logic             fetch;

    logic [7:0]       data_lat;
    logic [3:0]       len_lat;
    logic             par_en_lat;
    logic             par_type_lat;
    logic             stop2_lat;
    logic [DIV_W-1:0] baud_lat;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;

    logic             bit_end;
    logic             last_bit;
    logic             len_ok;
    logic             parity_bit;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (tx_clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready   = !fifo_full;
    assign tx_busy    = (state != IDLE);
    assign bit_end    = (cnt == baud_lat);
    assign last_bit   = ({1'b0, bit_idx} == (len_lat - 4'd1));
    // Length is judged on the live input because it is latched on this same edge.
    assign len_ok     = (length >= LEN_MIN) && (length <= LEN_MAX);
    assign parity_bit = par_type_lat ? parity_calc(data_lat, len_lat)
                                     : ~parity_calc(data_lat, len_lat);

    // Next-state, next line level and pulse generation; tx is computed one
    // edge early so the registered line changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        cnt_next     = bit_end ? '0 : cnt + DIV_W'(1);
        bit_idx_next = bit_idx;
        tx_next      = tx;
        done_next    = 1'b0;
        err_next     = 1'b0;
        fetch        = 1'b0;
        fifo_pop     = 1'b0;

        case (state)
            IDLE: begin
                fetch = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = data_lat[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        bit_idx_next = '0;
                        if (par_en_lat) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP1;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = data_lat[bit_idx + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP1;
                    tx_next    = 1'b1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    if (stop2_lat) begin
                        state_next = STOP2;
                        tx_next    = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        fetch     = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    done_next = 1'b1;
                    fetch     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Idle or end of frame: take the next word straight away if one is waiting.
        if (fetch) begin
            cnt_next     = '0;
            bit_idx_next = '0;
            tx_next      = 1'b1;
            state_next   = IDLE;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (len_ok) begin
                    state_next = START;
                    tx_next    = 1'b0;
                end else begin
                    err_next = 1'b1;
                end
            end
        end
    end

    // State, counters and registered line outputs.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
            tx_done <= done_next;
            tx_err  <= err_next;
        end
    end

    // Capture the word and its frame settings at the pop so input changes
    // during the frame cannot disturb it.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            data_lat     <= '0;
            len_lat      <= '0;
            par_en_lat   <= 1'b0;
            par_type_lat <= 1'b0;
            stop2_lat    <= 1'b0;
            baud_lat     <= '0;
        end else if (fifo_pop) begin
            data_lat     <= fifo_rd_data;
            len_lat      <= length;
            par_en_lat   <= parity_en;
            par_type_lat <= parity_type;
            stop2_lat    <= stop2;
            baud_lat     <= baud_div;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model predicts every output each
// cycle, and directed scenarios pin exact waveforms and tx_done timing.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int LOG_N = 8192;

    logic                   tx_clk      = 1'b0;
    logic                   rst         = 1'b0;
    logic [DIV_W-1:0]       baud_div    = '0;
    logic [3:0]             length      = 4'd8;
    logic                   parity_en   = 1'b0;
    logic                   parity_type = 1'b0;
    logic                   stop2       = 1'b0;
    logic [7:0]             in_data     = '0;
    logic                   in_valid    = 1'b0;
    logic                   in_ready;
    logic                   tx;
    logic                   tx_busy;
    logic                   tx_done;
    logic                   tx_err;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0;
    int errors = 0;

    // Model state: words waiting, and the per-cycle line levels of the frame on the wire.
    logic [7:0] word_q[$];
    logic [0:0] exp_q[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;
    int         cyc    = 0;

    // Observations used by directed checks.
    logic tx_log [0:LOG_N-1];
    int   done_cyc[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;

    int a5_exp  [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int par_even[8]  = '{0, 1, 1, 0, 0, 1, 1, 1};
    int par_odd [8]  = '{0, 1, 1, 0, 0, 1, 0, 1};

    int c0, c1, d0, e0, zeros;

    uart_tx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .tx_clk      (tx_clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .fifo_level  (fifo_level)
    );

    // Clock
    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    // Expand one word into the line levels it produces, each held baud+1 cycles.
    task automatic build_frame(input logic [7:0] w, input int len, input logic pen,
                               input logic ptype, input logic s2, input int b);
        logic bits[$];
        logic p;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            bits.push_back(w[i]);
            p = p ^ w[i];
        end
        if (pen) bits.push_back(ptype ? p : ~p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r <= b; r++) exp_q.push_back(bits[k]);
        end
    endtask

    task automatic model_step();
        int         n_before;
        logic [7:0] w;
        cyc++;
        n_before = word_q.size();
        m_done   = 1'b0;
        m_err    = 1'b0;
        if (m_busy && exp_q.size() > 0) begin
            m_tx = exp_q.pop_front();
        end else begin
            m_done = m_busy;
            m_busy = 1'b0;
            m_tx   = 1'b1;
            if (n_before > 0) begin
                w = word_q.pop_front();
                if (length >= 4'd5 && length <= 4'd8) begin
                    build_frame(w, int'(length), parity_en, parity_type, stop2, int'(baud_div));
                    m_tx   = exp_q.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (in_valid && n_before < DEPTH) word_q.push_back(in_data);
    endtask

    // Reference model: advances on each edge, cleared by reset.
    initial begin
        forever begin
            @(posedge tx_clk or negedge rst);
            if (!rst) begin
                word_q.delete();
                exp_q.delete();
                m_tx   = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_err  = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Scoreboard compare on the falling edge, plus observation logging.
    initial begin
        forever begin
            @(negedge tx_clk);
            check("tx", 32'(tx), 32'(m_tx));
            check("tx_busy", 32'(tx_busy), 32'(m_busy));
            check("tx_done", 32'(tx_done), 32'(m_done));
            check("tx_err", 32'(tx_err), 32'(m_err));
            check("in_ready", 32'(in_ready), (word_q.size() < DEPTH) ? 32'd1 : 32'd0);
            check("fifo_level", 32'(fifo_level), word_q.size());
            if (cyc < LOG_N) tx_log[cyc] = tx;
            if (tx_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (tx_err) err_cnt++;
        end
    end

    // Driver tasks: all called away from the rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, output int acc);
        bit got;
        got      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge tx_clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) check("push_ready_timeout", 32'd0, 32'd1);
        @(posedge tx_clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge tx_clk);
            if (word_q.size() == 0 && !m_busy && !tx_busy) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic wait_dones(input int base, input int n, input int max);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge tx_clk);
            if (done_cnt - base >= n) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic random_cfg();
        baud_div    = DIV_W'($urandom_range(0, 2));
        length      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(5, 8));
        parity_en   = 1'($urandom_range(0, 1));
        parity_type = 1'($urandom_range(0, 1));
        stop2       = 1'($urandom_range(0, 1));
    endtask

    initial begin
        // Reset state while rst is held low
        repeat (3) @(negedge tx_clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
        rst = 1'b1;
        wait_cycles(2);

        // Basic 8N1 frame of 0xA5, four clocks per bit
        baud_div = 16'd3; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        d0 = done_cnt;
        push_word(8'hA5, c0);
        wait_cycles(44);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("a5_bit%0d", k), 32'(tx_log[c0 + 1 + 4 * k + j]), a5_exp[k]);
            end
        end
        check("a5_done_count", done_cnt - d0, 32'd1);
        check("a5_done_cycle", done_cyc[$], c0 + 41);
        wait_drain(100);

        // Parity over five bits of 0xF3, one clock per bit
        baud_div = 16'd0; length = 4'd5; parity_en = 1'b1; parity_type = 1'b1;
        push_word(8'hF3, c0);
        wait_cycles(12);
        for (int k = 0; k < 8; k++) check($sformatf("even_bit%0d", k), 32'(tx_log[c0 + 1 + k]), par_even[k]);
        check("even_done_cycle", done_cyc[$], c0 + 9);
        parity_type = 1'b0;
        push_word(8'hF3, c0);
        wait_cycles(12);
        for (int k = 0; k < 8; k++) check($sformatf("odd_bit%0d", k), 32'(tx_log[c0 + 1 + k]), par_odd[k]);
        wait_drain(100);

        // Five back-to-back pushes: the first word leaves for the line one edge
        // after it lands, so the fifth accept is the one that fills the FIFO
        baud_div = 16'd1; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        d0 = done_cnt;
        push_word(8'($urandom_range(0, 255)), c1);
        for (int k = 0; k < 4; k++) push_word(8'($urandom_range(0, 255)), c0);
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        wait_dones(d0, 5, 400);
        wait_cycles(10);
        check("b2b_done_count", done_cnt - d0, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("b2b_done%0d", k), done_cyc[done_cyc.size() - 6 + k], c1 + 1 + 20 * k);
        end
        wait_drain(100);

        // Illegal length drops the word, then a legal word goes out normally
        baud_div = 16'd2; length = 4'd9;
        d0 = done_cnt; e0 = err_cnt;
        push_word(8'h55, c0);
        wait_cycles(20);
        check("bad_len_err", err_cnt - e0, 32'd1);
        check("bad_len_no_done", done_cnt - d0, 32'd0);
        zeros = 0;
        for (int k = 0; k < 20; k++) if (tx_log[c0 + k] !== 1'b1) zeros++;
        check("bad_len_line_high", zeros, 32'd0);
        length = 4'd8;
        push_word(8'h55, c1);
        wait_cycles(35);
        check("good_after_bad_done", done_cnt - d0, 32'd1);
        check("good_after_bad_cycle", done_cyc[$], c1 + 31);
        check("good_after_bad_no_err", err_cnt - e0, 32'd1);
        wait_drain(100);

        // stop2 raised during DATA affects only the following frame
        baud_div = 16'd1; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        d0 = done_cnt;
        push_word(8'h3C, c0);
        push_word(8'hC3, c1);
        wait_cycles(6);
        stop2 = 1'b1;
        wait_dones(d0, 2, 200);
        check("cfg_done1", done_cyc[$-1], c0 + 21);
        check("cfg_done2", done_cyc[$], c0 + 43);
        stop2 = 1'b0;
        wait_drain(100);

        // Reset in the middle of DATA with three words still queued
        baud_div = 16'd3; length = 4'd8;
        push_word(8'h81, c0);
        for (int k = 0; k < 3; k++) push_word(8'($urandom_range(0, 255)), c1);
        wait_cycles(8);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        d0 = done_cnt;
        @(negedge tx_clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge tx_clk);
        rst = 1'b1;
        wait_cycles(60);
        check("post_rst_no_done", done_cnt - d0, 32'd0);
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        // Randomized traffic and configuration against the model
        random_cfg();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) random_cfg();
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom_range(0, 255));
            @(posedge tx_clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
